// File: rtl/axis_traffic_gen.sv
// rtl/axis_traffic_gen.sv - AXI-Stream LFSR packet generator with counting slave sink.
// Master emits PKT_COUNT packets of PKT_LEN beats; slave accepts everything and counts beats/packets.
module axis_traffic_gen #(
  parameter int                TDATAW    = 32,
  parameter int                TDESTW    = 4,
  parameter int                TIDW      = 2,
  parameter int                NUM_DEST  = 4,
  parameter int                MAX_BEATS = 16,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1,
  parameter logic [TIDW-1:0]   SRC_ID    = '0,
  localparam int               BEATW     = $clog2(MAX_BEATS + 1)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic [15:0]       pkt_count_i,
  input  logic [BEATW-1:0]  pkt_len_i,
  input  logic [1:0]        dest_mode_i,
  input  logic [TDESTW-1:0] dest_fixed_i,
  output logic              busy_o,
  output logic              done_o,
  input  logic              axis_s_tvalid_i,
  output logic              axis_s_tready_o,
  input  logic [TDATAW-1:0] axis_s_tdata_i,
  input  logic              axis_s_tlast_i,
  input  logic [TIDW-1:0]   axis_s_tid_i,
  input  logic [TDESTW-1:0] axis_s_tdest_i,
  output logic              axis_m_tvalid_o,
  input  logic              axis_m_tready_i,
  output logic [TDATAW-1:0] axis_m_tdata_o,
  output logic              axis_m_tlast_o,
  output logic [TIDW-1:0]   axis_m_tid_o,
  output logic [TDESTW-1:0] axis_m_tdest_o,
  output logic [15:0]       rx_beat_cnt_o,
  output logic [15:0]       rx_pkt_cnt_o
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_FIN} state_t;

  state_t              state_q;
  logic [LFSR_W-1:0]   lfsr_q;
  logic [BEATW-1:0]    len_q;
  logic [BEATW-1:0]    beat_q;
  logic [15:0]         pkt_left_q;
  logic [1:0]          mode_q;
  logic [TDESTW-1:0]   fixed_q;
  logic [TDESTW-1:0]   rr_q;
  logic [TDESTW-1:0]   dest_q;
  logic                stop_q;
  logic                tvalid_q;
  logic                busy_q;
  logic                done_q;
  logic                s_tready_q;
  logic [15:0]         rx_beat_q;
  logic [15:0]         rx_pkt_q;

  logic [BEATW-1:0]    len_eff;
  logic [LFSR_W-1:0]   lfsr_nx;
  logic [TDESTW-1:0]   rr_inc;
  logic                accept;
  logic                last_beat;
  logic                unused_s;

  assign unused_s  = ^{axis_s_tdata_i, axis_s_tid_i, axis_s_tdest_i};

  always_comb begin
    len_eff = pkt_len_i;
    if (pkt_len_i == '0)
      len_eff = BEATW'(1);
    else if (pkt_len_i > BEATW'(MAX_BEATS))
      len_eff = BEATW'(MAX_BEATS);
  end

  assign lfsr_nx   = {lfsr_q[LFSR_W-2:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign rr_inc    = (rr_q == TDESTW'(NUM_DEST - 1)) ? '0 : rr_q + TDESTW'(1);
  assign accept    = tvalid_q & axis_m_tready_i;
  assign last_beat = (beat_q == len_q);

  // Destination is chosen from the LFSR value that the packet's first beat will carry.
  function automatic logic [TDESTW-1:0] pick_dest(input logic [1:0] mode,
                                                  input logic [TDESTW-1:0] fixed,
                                                  input logic [TDESTW-1:0] rr,
                                                  input logic [LFSR_W-1:0] v);
    logic [LFSR_W-1:0] masked;
    masked = v & LFSR_W'(NUM_DEST - 1);
    case (mode)
      2'd0:    return fixed;
      2'd1:    return rr;
      default: return TDESTW'(masked);
    endcase
  endfunction

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      lfsr_q     <= LFSR_SEED;
      len_q      <= BEATW'(1);
      beat_q     <= BEATW'(1);
      pkt_left_q <= '0;
      mode_q     <= '0;
      fixed_q    <= '0;
      rr_q       <= '0;
      dest_q     <= '0;
      stop_q     <= 1'b0;
      tvalid_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      s_tready_q <= 1'b0;
      rx_beat_q  <= '0;
      rx_pkt_q   <= '0;
    end else begin
      s_tready_q <= 1'b1;
      done_q     <= 1'b0;
      if (axis_s_tvalid_i && s_tready_q) begin
        rx_beat_q <= rx_beat_q + 16'd1;
        if (axis_s_tlast_i) rx_pkt_q <= rx_pkt_q + 16'd1;
      end
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            lfsr_q     <= LFSR_SEED;
            rx_beat_q  <= '0;
            rx_pkt_q   <= '0;
            len_q      <= len_eff;
            beat_q     <= BEATW'(1);
            mode_q     <= dest_mode_i;
            fixed_q    <= dest_fixed_i;
            pkt_left_q <= pkt_count_i;
            stop_q     <= 1'b0;
            if (pkt_count_i == '0) begin
              state_q <= S_FIN;
              done_q  <= 1'b1;
            end else begin
              state_q  <= S_SEND;
              busy_q   <= 1'b1;
              tvalid_q <= 1'b1;
              dest_q   <= pick_dest(dest_mode_i, dest_fixed_i, rr_q, LFSR_SEED);
              if (dest_mode_i == 2'd1) rr_q <= rr_inc;
            end
          end
        end
        S_SEND: begin
          if (stop_i) stop_q <= 1'b1;
          if (accept) begin
            lfsr_q <= lfsr_nx;
            if (last_beat) begin
              beat_q     <= BEATW'(1);
              pkt_left_q <= pkt_left_q - 16'd1;
              if (pkt_left_q == 16'd1 || stop_q || stop_i) begin
                state_q  <= S_FIN;
                tvalid_q <= 1'b0;
                busy_q   <= 1'b0;
                done_q   <= 1'b1;
                dest_q   <= '0;
              end else begin
                dest_q <= pick_dest(mode_q, fixed_q, rr_q, lfsr_nx);
                if (mode_q == 2'd1) rr_q <= rr_inc;
              end
            end else begin
              beat_q <= beat_q + BEATW'(1);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign axis_s_tready_o = s_tready_q;
  assign axis_m_tvalid_o = tvalid_q;
  assign axis_m_tdata_o  = tvalid_q ? TDATAW'(lfsr_q) : '0;
  assign axis_m_tlast_o  = tvalid_q & last_beat;
  assign axis_m_tid_o    = SRC_ID;
  assign axis_m_tdest_o  = tvalid_q ? dest_q : '0;
  assign rx_beat_cnt_o   = rx_beat_q;
  assign rx_pkt_cnt_o    = rx_pkt_q;

endmodule

// File: tb/tb_axis_traffic_gen.sv
// tb/tb_axis_traffic_gen.sv - scoreboard bench for axis_traffic_gen.
module tb_axis_traffic_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0;
  logic [15:0] pkt_count = '0;
  logic [4:0]  pkt_len = '0;
  logic [1:0]  dest_mode = '0;
  logic [3:0]  dest_fixed = '0;
  logic        busy, done;
  logic        s_tvalid = 1'b0, s_tready, s_tlast = 1'b0;
  logic [31:0] s_tdata = '0;
  logic [1:0]  s_tid = '0;
  logic [3:0]  s_tdest = '0;
  logic        m_tvalid, m_tready = 1'b1, m_tlast;
  logic [31:0] m_tdata;
  logic [1:0]  m_tid;
  logic [3:0]  m_tdest;
  logic [15:0] rx_beat_cnt, rx_pkt_cnt;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [3:0]  dest;
  } beat_t;

  beat_t exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    acc_cnt = 0;
  int    rr_m = 0;
  logic  hold_pending = 1'b0;
  beat_t hold_b;

  axis_traffic_gen dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .stop_i(stop),
    .pkt_count_i(pkt_count), .pkt_len_i(pkt_len), .dest_mode_i(dest_mode),
    .dest_fixed_i(dest_fixed), .busy_o(busy), .done_o(done),
    .axis_s_tvalid_i(s_tvalid), .axis_s_tready_o(s_tready), .axis_s_tdata_i(s_tdata),
    .axis_s_tlast_i(s_tlast), .axis_s_tid_i(s_tid), .axis_s_tdest_i(s_tdest),
    .axis_m_tvalid_o(m_tvalid), .axis_m_tready_i(m_tready), .axis_m_tdata_o(m_tdata),
    .axis_m_tlast_o(m_tlast), .axis_m_tid_o(m_tid), .axis_m_tdest_o(m_tdest),
    .rx_beat_cnt_o(rx_beat_cnt), .rx_pkt_cnt_o(rx_pkt_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic b;
    b = v[15] ^ v[13] ^ v[12] ^ v[10];
    return {v[14:0], b};
  endfunction

  // Output monitor: pops the scoreboard on every accepted beat and checks stalled beats hold.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_tvalid && hold_pending) begin
        n_vec++;
        if ({m_tdata, m_tlast, m_tdest} !== hold_b) begin
          n_err++;
          $display("FAIL hold: got %h want %h", {m_tdata, m_tlast, m_tdest}, hold_b);
        end
      end
      if (m_tvalid && m_tready) begin
        acc_cnt++;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL beat: unexpected beat data=%h", m_tdata);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          if ({m_tdata, m_tlast, m_tdest} !== e || m_tid !== 2'd0) begin
            n_err++;
            $display("FAIL beat: got data=%h last=%b dest=%0d tid=%0d want data=%h last=%b dest=%0d tid=0",
                     m_tdata, m_tlast, m_tdest, m_tid, e.data, e.last, e.dest);
          end
        end
      end
      hold_pending = m_tvalid && !m_tready;
      hold_b = {m_tdata, m_tlast, m_tdest};
    end else begin
      hold_pending = 1'b0;
    end
  end

  task automatic push_run(input int len, input int mode, input logic [3:0] fixed, input int npk);
    logic [15:0] v;
    logic [3:0]  d;
    int          el;
    beat_t       e;
    v  = 16'hACE1;
    d  = '0;
    el = (len == 0) ? 1 : (len > 16) ? 16 : len;
    for (int p = 0; p < npk; p++) begin
      for (int b = 0; b < el; b++) begin
        if (b == 0) begin
          if (mode == 0) d = fixed;
          else if (mode == 1) begin d = 4'(rr_m); rr_m = (rr_m + 1) % 4; end
          else d = {2'b00, v[1:0]};
        end
        e.data = {16'h0000, v};
        e.last = (b == el - 1);
        e.dest = d;
        exp_q.push_back(e);
        v = lfsr_step(v);
      end
    end
  endtask

  task automatic start_run(input logic [15:0] c, input logic [4:0] l, input logic [1:0] m,
                           input logic [3:0] f, input logic with_stop);
    @(posedge clk); #1;
    pkt_count = c; pkt_len = l; dest_mode = m; dest_fixed = f;
    start = 1'b1; stop = with_stop;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int n, output int busy_n, output int vld_n,
                           output bit ok);
    n = 0; busy_n = 0; vld_n = 0; ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      n++;
      if (busy) busy_n++;
      if (m_tvalid) vld_n++;
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic check_run(input string name, input int n, input bit ok, input int want_n);
    n_vec++;
    if (!ok || n != want_n) begin
      n_err++;
      $display("FAIL %s done: ok=%0d cycles=%0d want cycles=%0d", name, ok, n, want_n);
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s scoreboard: %0d beats left, want 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    #12;
    n_vec++;
    if ({m_tvalid, m_tdata, m_tlast, m_tid, m_tdest, busy, done, s_tready, rx_beat_cnt, rx_pkt_cnt} !== '0) begin
      n_err++;
      $display("FAIL reset outputs: got valid=%b data=%h last=%b dest=%0d busy=%b done=%b sready=%b rx=%0d/%0d want all 0",
               m_tvalid, m_tdata, m_tlast, m_tdest, busy, done, s_tready, rx_beat_cnt, rx_pkt_cnt);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    n_vec++;
    if (s_tready !== 1'b1) begin
      n_err++;
      $display("FAIL s_tready after reset: got %b want 1", s_tready);
    end
  endtask

  task automatic test_slave();
    bit v[9]   = '{1, 1, 1, 0, 1, 1, 0, 1, 1};
    bit lst[9] = '{0, 0, 1, 0, 0, 0, 1, 0, 1};
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      s_tvalid = v[i]; s_tlast = lst[i]; s_tdata = $urandom;
    end
    @(posedge clk); #1; s_tvalid = 1'b0; s_tlast = 1'b0;
    @(negedge clk);
    n_vec++;
    if (rx_beat_cnt !== 16'd7) begin n_err++; $display("FAIL rx_beat_cnt: got %0d want 7", rx_beat_cnt); end
    n_vec++;
    if (rx_pkt_cnt !== 16'd2) begin n_err++; $display("FAIL rx_pkt_cnt: got %0d want 2", rx_pkt_cnt); end
  endtask

  task automatic test_single_packet();
    int n, b, vl; bit ok; beat_t e;
    e = '{data: 32'h0000ACE1, last: 1'b0, dest: 4'd3}; exp_q.push_back(e);
    e = '{data: 32'h000059C3, last: 1'b1, dest: 4'd3}; exp_q.push_back(e);
    start_run(16'd1, 5'd2, 2'd0, 4'd3, 1'b0);
    wait_done(50, n, b, vl, ok);
    check_run("single", n, ok, 3);
    n_vec++;
    if ({rx_beat_cnt, rx_pkt_cnt} !== 32'd0) begin
      n_err++; $display("FAIL start clears rx: got %0d/%0d want 0/0", rx_beat_cnt, rx_pkt_cnt);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0) begin n_err++; $display("FAIL done width: got %b want 0", done); end
  endtask

  task automatic test_backpressure();
    int n, b, vl; bit ok; beat_t e;
    e = '{data: 32'h0000ACE1, last: 1'b0, dest: 4'd3}; exp_q.push_back(e);
    e = '{data: 32'h000059C3, last: 1'b1, dest: 4'd3}; exp_q.push_back(e);
    m_tready = 1'b0;
    start_run(16'd1, 5'd2, 2'd0, 4'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (m_tvalid !== 1'b1 || m_tdata !== 32'h0000ACE1) begin
        n_err++; $display("FAIL stall %0d: got valid=%b data=%h want 1/0000ace1", i, m_tvalid, m_tdata);
      end
    end
    @(posedge clk); #1; m_tready = 1'b1;
    wait_done(50, n, b, vl, ok);
    check_run("backpressure", n, ok, 3);
  endtask

  task automatic test_round_robin();
    int n, b, vl; bit ok;
    push_run(1, 1, 4'd0, 5);
    start_run(16'd5, 5'd1, 2'd1, 4'd0, 1'b0);
    wait_done(50, n, b, vl, ok);
    check_run("round_robin", n, ok, 6);
    n_vec++;
    if (b != 5) begin n_err++; $display("FAIL rr busy cycles: got %0d want 5", b); end
  endtask

  task automatic test_stop();
    int n, b, vl, a0; bit ok;
    push_run(4, 0, 4'd5, 3);
    a0 = acc_cnt;
    start_run(16'd100, 5'd4, 2'd0, 4'd5, 1'b0);
    repeat (9) @(posedge clk);
    #1; stop = 1'b1;
    @(posedge clk); #1; stop = 1'b0;
    wait_done(100, n, b, vl, ok);
    check_run("stop", n, ok, 3);
    n_vec++;
    if (acc_cnt - a0 != 12) begin n_err++; $display("FAIL stop beats: got %0d want 12", acc_cnt - a0); end
  endtask

  task automatic test_zero_and_restart();
    int n, b, vl; bit ok;
    start_run(16'd0, 5'd4, 2'd0, 4'd0, 1'b0);
    wait_done(20, n, b, vl, ok);
    check_run("zero_count", n, ok, 1);
    n_vec++;
    if (vl != 0 || b != 0) begin n_err++; $display("FAIL zero_count activity: valid=%0d busy=%0d want 0/0", vl, b); end
    push_run(3, 0, 4'd9, 2);
    start_run(16'd2, 5'd3, 2'd0, 4'd9, 1'b0);
    @(posedge clk); #1;
    pkt_count = 16'd50; pkt_len = 5'd1; dest_fixed = 4'd1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_done(50, n, b, vl, ok);
    check_run("start_in_send", n, ok, 5);
    repeat (4) @(negedge clk);
    n_vec++;
    if (m_tvalid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL after run: valid=%b busy=%b want 0/0", m_tvalid, busy);
    end
  endtask

  task automatic test_start_stop_idle();
    int n, b, vl; bit ok;
    push_run(2, 0, 4'd2, 3);
    start_run(16'd3, 5'd2, 2'd0, 4'd2, 1'b1);
    wait_done(50, n, b, vl, ok);
    check_run("start_stop_idle", n, ok, 7);
  endtask

  task automatic test_len_edges();
    int n, b, vl; bit ok;
    push_run(0, 0, 4'd4, 2);
    start_run(16'd2, 5'd0, 2'd0, 4'd4, 1'b0);
    wait_done(50, n, b, vl, ok);
    check_run("len_zero", n, ok, 3);
    push_run(20, 0, 4'd6, 1);
    start_run(16'd1, 5'd20, 2'd0, 4'd6, 1'b0);
    wait_done(50, n, b, vl, ok);
    check_run("len_clamp", n, ok, 17);
  endtask

  task automatic test_random_dest();
    bit ok;
    for (int m = 2; m < 4; m++) begin
      push_run(3, m, 4'd0, 6);
      start_run(16'd6, 5'd3, 2'(m), 4'd0, 1'b0);
      ok = 1'b0;
      for (int i = 0; i < 400 && !ok; i++) begin
        @(posedge clk); #1; m_tready = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (done) ok = 1'b1;
      end
      m_tready = 1'b1;
      check_run("random_dest", 0, ok, 0);
    end
  endtask

  task automatic test_reset_midrun();
    int n, b, vl, seen; bit ok;
    push_run(4, 0, 4'd1, 10);
    start_run(16'd10, 5'd4, 2'd0, 4'd1, 1'b0);
    repeat (5) @(posedge clk);
    #3; rst_n = 1'b0;
    #1;
    n_vec++;
    if ({m_tvalid, m_tdata, m_tlast, m_tid, m_tdest, busy, done, s_tready, rx_beat_cnt, rx_pkt_cnt} !== '0) begin
      n_err++;
      $display("FAIL midrun reset: valid=%b data=%h last=%b dest=%0d busy=%b done=%b sready=%b want all 0",
               m_tvalid, m_tdata, m_tlast, m_tdest, busy, done, s_tready);
    end
    exp_q.delete();
    rr_m = 0;
    @(posedge clk); #1; rst_n = 1'b1;
    seen = 0;
    repeat (10) begin @(negedge clk); if (done || m_tvalid) seen++; end
    n_vec++;
    if (seen != 0) begin n_err++; $display("FAIL after reset activity: got %0d cycles want 0", seen); end
    push_run(1, 1, 4'd0, 2);
    start_run(16'd2, 5'd1, 2'd1, 4'd0, 1'b0);
    wait_done(50, n, b, vl, ok);
    check_run("rr_after_reset", n, ok, 3);
  endtask

  initial begin
    test_reset();
    test_slave();
    test_single_packet();
    test_backpressure();
    test_round_robin();
    test_stop();
    test_zero_and_restart();
    test_start_stop_idle();
    test_len_edges();
    test_random_dest();
    test_reset_midrun();
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
